// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, operation width and error classification.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_DIV = 3'b011
    } alu_operation;

    // Codes 3'b100..3'b111 are unassigned; the top bit alone identifies them.
    function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
        return op[ALU_OP_W-1];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head is read combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally; the count register tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/alu_issue_q.sv
// Issue stage for the ALU: buffers tagged requests, issues one per cycle, captures the
// registered ALU result and returns it in order over a backpressured response port.
module alu_issue_q
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ALU_OP_W-1:0]   req_op_i,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic [ALU_OP_W-1:0]   alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_src_a_o,
    output logic [DATA_WIDTH-1:0] alu_src_b_o,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic [TAG_WIDTH-1:0]  rsp_tag_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [TAG_WIDTH-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  err;
    } rsp_t;

    localparam int REQ_W      = $bits(req_t);
    localparam int RSP_W      = $bits(rsp_t);
    localparam int REQ_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int RSP_DEPTH  = 2;
    localparam int RSP_CNT_W  = $clog2(RSP_DEPTH + 1);

    req_t                 req_wdata, req_head;
    logic [REQ_CNT_W-1:0] req_count;
    logic                 req_empty;
    logic                 req_push;

    rsp_t                 rsp_wdata, rsp_head;
    logic [RSP_CNT_W-1:0] rsp_count;
    logic                 rsp_empty;
    logic                 rsp_pop;

    logic                 issue;
    logic [2:0]           occupancy;
    logic                 head_illegal, head_divz;

    logic                  infl_vld_q, infl_vld_d;
    logic [TAG_WIDTH-1:0]  infl_tag_q, infl_tag_d;
    logic                  infl_illegal_q, infl_illegal_d;
    logic                  infl_divz_q, infl_divz_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;

    assign req_wdata   = '{op: req_op_i, a: req_a_i, b: req_b_i, tag: req_tag_i};
    // Ready comes from the registered count only, so a same-cycle pop never raises it.
    assign req_ready_o = (req_count != REQ_CNT_W'(FIFO_DEPTH));
    assign req_push    = req_valid_i && req_ready_o;

    sync_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_push),
        .wdata_i (req_wdata),
        .pop_i   (issue),
        .rdata_o (req_head),
        .count_o (req_count),
        .empty_o (req_empty)
    );

    assign rsp_valid_o = !rsp_empty;
    assign rsp_pop     = rsp_valid_o && rsp_ready_i;

    // Never allow more than two results between the ALU and the response port.
    assign occupancy = 3'(infl_vld_q) + 3'(rsp_count) - 3'(rsp_pop);
    assign issue     = !req_empty && (occupancy < 3'd2);

    assign head_illegal = op_is_illegal(req_head.op);
    assign head_divz    = (req_head.op == ALU_DIV) && (req_head.b == '0);

    always_comb begin
        alu_op_d       = alu_op_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        infl_vld_d     = issue;
        infl_tag_d     = infl_tag_q;
        infl_illegal_d = infl_illegal_q;
        infl_divz_d    = infl_divz_q;
        if (issue) begin
            alu_op_d       = req_head.op;
            alu_a_d        = req_head.a;
            alu_b_d        = req_head.b;
            infl_tag_d     = req_head.tag;
            infl_illegal_d = head_illegal;
            infl_divz_d    = head_divz;
        end
    end

    assign alu_op_o    = alu_op_d;
    assign alu_src_a_o = alu_a_d;
    assign alu_src_b_o = alu_b_d;

    always_comb begin
        rsp_wdata.tag    = infl_tag_q;
        rsp_wdata.err    = infl_illegal_q || infl_divz_q;
        rsp_wdata.result = alu_result_i;
        if (infl_illegal_q) begin
            rsp_wdata.result = '0;
        end else if (infl_divz_q) begin
            rsp_wdata.result = '1;
        end
    end

    sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (infl_vld_q),
        .wdata_i (rsp_wdata),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .count_o (rsp_count),
        .empty_o (rsp_empty)
    );

    assign rsp_result_o = rsp_head.result;
    assign rsp_tag_o    = rsp_head.tag;
    assign rsp_err_o    = rsp_head.err;
    assign busy_o       = !req_empty || infl_vld_q || !rsp_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            infl_vld_q     <= 1'b0;
            infl_tag_q     <= '0;
            infl_illegal_q <= 1'b0;
            infl_divz_q    <= 1'b0;
            alu_op_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
        end else begin
            infl_vld_q     <= infl_vld_d;
            infl_tag_q     <= infl_tag_d;
            infl_illegal_q <= infl_illegal_d;
            infl_divz_q    <= infl_divz_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_q.sv
// Randomised scoreboard bench for alu_issue_q with a behavioural result model and an ALU stand-in.
`timescale 1ns/1ps
module tb_alu_issue_q;

    localparam int DW    = 8;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [2:0]    req_op_i = '0;
    logic [DW-1:0] req_a_i = '0;
    logic [DW-1:0] req_b_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic [2:0]    alu_op_o;
    logic [DW-1:0] alu_src_a_o;
    logic [DW-1:0] alu_src_b_o;
    logic [DW-1:0] alu_result_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b1;
    logic [DW-1:0] rsp_result_o;
    logic [TW-1:0] rsp_tag_o;
    logic          rsp_err_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    alu_issue_q #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .req_tag_i    (req_tag_i),
        .alu_op_o     (alu_op_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_result_i (alu_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_tag_o    (rsp_tag_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    // ALU stand-in with a one-cycle registered result; error cases return junk on purpose.
    always @(posedge clk_i) begin
        case (alu_op_o)
            3'd0:    alu_result_i <= alu_src_a_o + alu_src_b_o;
            3'd1:    alu_result_i <= alu_src_a_o - alu_src_b_o;
            3'd2:    alu_result_i <= alu_src_a_o * alu_src_b_o;
            3'd3:    alu_result_i <= (alu_src_b_o == '0) ? 8'h5A : alu_src_a_o / alu_src_b_o;
            default: alu_result_i <= 8'hA5;
        endcase
    end

    typedef struct {
        int result;
        int tag;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cyc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic int model_result(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return (a * b) % 256;
            3:       return (b == 0) ? 255 : a / b;
            default: return 0;
        endcase
    endfunction

    function automatic int model_err(input int op, input int b);
        return ((op > 3) || (op == 3 && b == 0)) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
    logic             held_v = 1'b0;
    logic [DW+TW:0]   held_val;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!rsp_valid_o || {rsp_result_o, rsp_tag_o, rsp_err_o} != held_val) begin
                    errors++;
                    $display("FAIL rsp_stable: got valid=%0b %h required valid=1 %h",
                             rsp_valid_o, {rsp_result_o, rsp_tag_o, rsp_err_o}, held_val);
                end
            end
            held_v = rsp_valid_o && !rsp_ready_i;
            held_val = {rsp_result_o, rsp_tag_o, rsp_err_o};
            if (rsp_valid_o && rsp_ready_i) begin
                checks++;
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got result=%0d tag=%0d err=%0d required none",
                             rsp_result_o, rsp_tag_o, rsp_err_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(rsp_result_o) != e.result || int'(rsp_tag_o) != e.tag ||
                        int'(rsp_err_o) != e.err) begin
                        errors++;
                        $display("FAIL rsp_data: got result=%0d tag=%0d err=%0d required result=%0d tag=%0d err=%0d",
                                 rsp_result_o, rsp_tag_o, rsp_err_o, e.result, e.tag, e.err);
                    end else begin
                        $display("rsp tag=%0d result=%0d err=%0d cycle=%0d",
                                 rsp_tag_o, rsp_result_o, rsp_err_o, cyc);
                    end
                end
            end
        end
    end

    task automatic send(input int op, input int a, input int b, input int tag);
        int   waited;
        exp_t e;
        waited      = 0;
        req_valid_i = 1'b1;
        req_op_i    = op[2:0];
        req_a_i     = a[DW-1:0];
        req_b_i     = b[DW-1:0];
        req_tag_i   = tag[TW-1:0];
        @(negedge clk_i);
        while (!req_ready_o && waited < 50) begin
            waited++;
            @(negedge clk_i);
        end
        if (!req_ready_o) begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got ready=0 required ready=1 tag=%0d", tag);
        end else begin
            e.result = model_result(op, a, b);
            e.tag    = tag;
            e.err    = model_err(op, b);
            exp_q.push_back(e);
            last_acc_cyc = cyc;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, int'(req_ready_o), 1);
        check({tag, "_rsp_valid"}, int'(rsp_valid_o), 0);
        check({tag, "_rsp_result"}, int'(rsp_result_o), 0);
        check({tag, "_rsp_tag"}, int'(rsp_tag_o), 0);
        check({tag, "_rsp_err"}, int'(rsp_err_o), 0);
        check({tag, "_alu_op"}, int'(alu_op_o), 0);
        check({tag, "_alu_a"}, int'(alu_src_a_o), 0);
        check({tag, "_alu_b"}, int'(alu_src_b_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
    endtask

    initial begin
        int first_acc;
        int last_rsp;

        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset_state");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single add into an idle block.
        rsp_cyc_q.delete();
        send(0, 5, 3, 1);
        wait_drain();
        last_rsp = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[rsp_cyc_q.size()-1] : -1;
        check("single_add_latency", last_rsp - last_acc_cyc, 3);
        @(negedge clk_i);
        check("single_add_busy_idle", int'(busy_o), 0);
        @(posedge clk_i);
        #1;

        // Stream of six with the response port stalled: FIFO + response buffer absorb all six.
        rsp_ready_i = 1'b0;
        send(1, 10, 4, 2);
        send(2, 7, 3, 3);
        send(3, 20, 6, 4);
        send(0, 255, 1, 5);
        send(1, 0, 1, 6);
        send(2, 16, 16, 8);
        @(negedge clk_i);
        check("stream_req_ready_full", int'(req_ready_o), 0);
        check("stream_busy", int'(busy_o), 1);
        @(posedge clk_i);
        #1;
        rsp_ready_i = 1'b1;
        wait_drain();

        // Divide by zero, then an illegal op followed by a legal one.
        send(3, 9, 0, 7);
        wait_drain();
        send(5, 1, 1, 9);
        send(0, 3, 4, 10);
        send(7, 200, 0, 11);
        wait_drain();

        // Reset with work queued and buffered.
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(0, i, i, 12);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        rsp_cyc_q.delete();
        send(0, 2, 2, 13);
        wait_drain();
        repeat (6) @(posedge clk_i);
        #1;
        check("post_reset_rsp_count", rsp_cyc_q.size(), 1);

        // Sixteen random legal requests back to back.
        rsp_cyc_q.delete();
        first_acc = -1;
        for (int i = 0; i < 16; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), i);
            if (first_acc < 0) first_acc = last_acc_cyc;
        end
        wait_drain();
        check("thru_rsp_count", rsp_cyc_q.size(), 16);
        if (rsp_cyc_q.size() == 16) begin
            check("thru_first_latency", rsp_cyc_q[0] - first_acc, 3);
            check("thru_span", rsp_cyc_q[15] - rsp_cyc_q[0], 15);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
